seven_seg_capture: RTL

- Receive side of the stopwatch display interface: samples the multiplexed, active-low seven-segment bus (CA..CG, AN0..AN3) as the stopwatch drives it.
- Reconstructs the four displayed digits as 4-bit BCD, flags malformed scan activity, and pulses once per complete display refresh.
- Used as an on-chip display monitor and as a self-checking capture block in stopwatch benches.

---
 rtl/seven_seg_capture.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/seven_seg_capture.sv
// Display monitor for the multiplexed, active-low seven-segment bus.
// Recovers four BCD digits and flags ghosting and malformed patterns.
module seven_seg_capture #(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic       clk_100mhz,
    input  logic       rst_n,
    input  logic       CA,
    input  logic       CB,
    input  logic       CC,
    input  logic       CD,
    input  logic       CE,
    input  logic       CF,
    input  logic       CG,
    input  logic       AN0,
    input  logic       AN1,
    input  logic       AN2,
    input  logic       AN3,
    output logic [3:0] digit0,
    output logic [3:0] digit1,
    output logic [3:0] digit2,
    output logic [3:0] digit3,
    output logic [3:0] digit_valid,
    output logic       frame_valid,
    output logic       seg_error,
    output logic       ghost_error
);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        HOLD
    } state_t;

    localparam logic [7:0] SETTLE_LIM = 8'(SETTLE_CYCLES);

    state_t state, state_d;

    logic [6:0] seg_q;
    logic [3:0] an_q;
    logic [3:0] act;
    logic [2:0] n_act;
    logic       none_act;
    logic       one_act;
    logic       multi_act;
    logic [1:0] cur_idx;

    logic [1:0] lat_idx;
    logic [6:0] lat_seg;
    logic [7:0] cnt;
    logic [7:0] cnt_d;
    logic       load;
    logic       inc;
    logic       capture;

    logic [3:0][3:0] dig;
    logic [3:0]      mask;
    logic [3:0]      cap_bit;
    logic            multi_q;
    logic            dec_ok;
    logic [3:0]      dec_code;

    // Bus sampled once; every decision below uses this copy only.
    always_ff @(posedge clk_100mhz) begin
        if (!rst_n) begin
            seg_q <= '1;
            an_q  <= '1;
        end else begin
            seg_q <= {CG, CF, CE, CD, CC, CB, CA};
            an_q  <= {AN3, AN2, AN1, AN0};
        end
    end

    assign act       = ~an_q;
    assign n_act     = 3'(act[0]) + 3'(act[1]) + 3'(act[2]) + 3'(act[3]);
    assign none_act  = (n_act == 3'd0);
    assign one_act   = (n_act == 3'd1);
    assign multi_act = !none_act && !one_act;

    always_comb begin
        cur_idx = 2'd0;
        case (1'b1)
            act[0]:  cur_idx = 2'd0;
            act[1]:  cur_idx = 2'd1;
            act[2]:  cur_idx = 2'd2;
            act[3]:  cur_idx = 2'd3;
            default: cur_idx = 2'd0;
        endcase
    end

    always_comb begin
        dec_ok   = 1'b1;
        dec_code = 4'hF;
        case (seg_q)
            7'b1000000: dec_code = 4'd0;
            7'b1111001: dec_code = 4'd1;
            7'b0100100: dec_code = 4'd2;
            7'b0110000: dec_code = 4'd3;
            7'b0011001: dec_code = 4'd4;
            7'b0010010: dec_code = 4'd5;
            7'b0000010: dec_code = 4'd6;
            7'b1111000: dec_code = 4'd7;
            7'b0000000: dec_code = 4'd8;
            7'b0010000: dec_code = 4'd9;
            7'b1111111: dec_code = 4'hF;
            default:    dec_ok   = 1'b0;
        endcase
    end

    always_ff @(posedge clk_100mhz) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    always_comb begin
        state_d = state;
        load    = 1'b0;
        inc     = 1'b0;
        capture = 1'b0;
        cnt_d   = cnt;
        case (state)
            IDLE: begin
                if (one_act) load = 1'b1;
            end
            SETTLE: begin
                if (one_act && cur_idx == lat_idx && seg_q == lat_seg)
                    inc = 1'b1;
                else if (one_act)
                    load = 1'b1;
                else
                    state_d = IDLE;
            end
            HOLD: begin
                if (one_act && cur_idx == lat_idx)
                    state_d = HOLD;
                else if (one_act)
                    load = 1'b1;
                else
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (load) begin
            cnt_d   = 8'd1;
            state_d = SETTLE;
        end
        if (inc) cnt_d = cnt + 8'd1;
        // A load can already satisfy a one-cycle settle requirement.
        if ((load || inc) && cnt_d == SETTLE_LIM) begin
            capture = 1'b1;
            state_d = HOLD;
        end
    end

    always_ff @(posedge clk_100mhz) begin
        if (!rst_n) begin
            cnt     <= '0;
            lat_idx <= '0;
            lat_seg <= '1;
        end else begin
            if (load || inc) cnt <= cnt_d;
            if (load) begin
                lat_idx <= cur_idx;
                lat_seg <= seg_q;
            end
        end
    end

    assign cap_bit = 4'b0001 << cur_idx;

    always_ff @(posedge clk_100mhz) begin
        if (!rst_n) begin
            dig         <= {4{4'hF}};
            digit_valid <= '0;
            mask        <= '0;
            frame_valid <= 1'b0;
            seg_error   <= 1'b0;
            ghost_error <= 1'b0;
            multi_q     <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            seg_error   <= 1'b0;
            multi_q     <= multi_act;
            ghost_error <= multi_act && !multi_q;
            if (capture) begin
                if (dec_ok) begin
                    dig[cur_idx]         <= dec_code;
                    digit_valid[cur_idx] <= 1'b1;
                    if ((mask | cap_bit) == 4'hF) begin
                        frame_valid <= 1'b1;
                        mask        <= '0;
                    end else begin
                        mask <= mask | cap_bit;
                    end
                end else begin
                    seg_error <= 1'b1;
                end
            end
        end
    end

    assign digit0 = dig[0];
    assign digit1 = dig[1];
    assign digit2 = dig[2];
    assign digit3 = dig[3];

endmodule
